hamming_sequencer: RTL and testbench
====================================

// Module: hamming_sequencer
// PURPOSE
//  Sequences one Hamming(7,4) transaction through the codec datapath: load, encode, error-inject,
//  syndrome, optional correct, result handoff. Owns the 3-bit state code Q and its one-hot timing
//  word T, and derives the datapath enables from T. Sits between the top-level stimulus/host and the
//  encoder, channel and decoder/corrector blocks. Also keeps a saturating count of corrected words.
// PARAMETERS
//  INJECT_EN  1  1: INJECT phase is visited. 0: ENCODE goes straight to SYNDROME and inj_en never asserts.
//  CNT_W      8  width of err_cnt; saturates at 2**CNT_W-1.
// PORTS
//  clk            in   1      system clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      request a transaction; accepted only when start_ready=1
//  start_ready    out  1      1 iff Q==IDLE
//  syn_nonzero    in   1      decoder syndrome != 0; sampled only in SYNDROME
//  out_ready      in   1      consumer accepts the result
//  out_valid      out  1      1 iff Q==DONE
//  out_corrected  out  1      registered; 1 if this transaction passed through CORRECT; valid with out_valid
//  load_en        out  1      = T[1]; datapath latches the input nibble
//  enc_en         out  1      = T[2]; encoder output register update
//  inj_en         out  1      = T[3] & INJECT_EN; channel applies the error pattern
//  syn_en         out  1      = T[4]; syndrome register update
//  cor_en         out  1      = T[5]; corrector writes the corrected codeword
//  Q              out  3      current state code
//  T              out  8      one-hot timing word, T[Q]=1
//  err_cnt        out  CNT_W  number of words corrected since reset or clr_cnt
//  clr_cnt        in   1      synchronous clear of err_cnt
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). rst overrides everything, including mid-transaction.
//  - Reset values: Q=0 (IDLE), T=8'b0000_0001, out_corrected=0, err_cnt=0. Derived outputs follow:
//    start_ready=1, out_valid=0, all *_en=0.
//  - State codes: IDLE=0, LOAD=1, ENCODE=2, INJECT=3, SYNDROME=4, CORRECT=5, DONE=6. Code 7 is illegal.
//  - Transitions, one per posedge:
//    IDLE: start -> LOAD, else stay.
//    LOAD -> ENCODE.
//    ENCODE -> INJECT if INJECT_EN, else SYNDROME.
//    INJECT -> SYNDROME.
//    SYNDROME: syn_nonzero -> CORRECT, else DONE.
//    CORRECT -> DONE.
//    DONE: out_ready -> IDLE, else hold. out_valid stays high until accepted.
//    Illegal code 7 -> IDLE on the next edge. T in that cycle is all-zero and every enable is 0.
//  - start while not IDLE is ignored and not queued.
//  - start sampled high in IDLE at edge 0 gives Q=LOAD after edge 0. DONE is reached after edge 5
//    when corrected, after edge 4 when not (INJECT_EN=1). Each without-INJECT path is one edge shorter.
//  - T and all enables decode the registered Q combinationally. They are glitch-free relative to
//    clk and never have more than one bit set.
//  - out_corrected: cleared on the LOAD entry edge; set on the CORRECT entry edge. Held through DONE.
//  - err_cnt: +1 on each edge that enters CORRECT, saturating at all-ones (no wrap).
//    If clr_cnt and an increment fall on the same edge, the clear wins and the result is 0.
//  - DONE with out_ready=1 and start=1 on the same edge: go to IDLE. start is taken next cycle,
//    giving one bubble cycle.
// STRUCTURE
//  - hamming_pkg: localparams for the state codes (ST_IDLE..ST_DONE) and the T-bit indices,
//    shared with the datapath and benches.
//  - Sub-module hamming_t_decode: combinational 3-to-8 one-hot decoder, Q -> T.
//    The enables are simple taps of T.
//  - The top holds the state register, the next-state logic, the out_corrected flag and the
//    saturating err_cnt.
// TESTING
//  1. rst=1 for 2 cycles -> Q=0, T=8'h01, err_cnt=0, start_ready=1. Then start=1 for 1 cycle,
//     syn_nonzero=0, out_ready=1 -> T sequence 02,04,08,10,40,01; out_corrected=0; err_cnt=0.
//  2. start with syn_nonzero=1 in SYNDROME -> T sequence 02,04,08,10,20,40; out_corrected=1;
//     err_cnt 0->1 on the CORRECT entry edge; cor_en high for exactly 1 cycle.
//  3. out_ready=0 for 5 cycles in DONE -> Q holds 6 and out_valid stays 1. A start pulse during
//     the hold is ignored. out_ready=1 -> Q=0 next edge.
//  4. CNT_W=2, 4 correcting transactions -> err_cnt 1,2,3,3. Then clr_cnt asserted on a
//     CORRECT-entry edge -> err_cnt=0.
//  5. rst asserted while Q=4 -> Q=0, T=01, out_corrected=0 after that edge. Force Q=7 -> T=00,
//     Q=0 next edge.
//  6. INJECT_EN=0 build -> T sequence 02,04,10,...; inj_en never 1.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared state codes and timing-word bit indices for the Hamming(7,4) codec
//
// Purpose: state encoding of the transaction sequencer and the matching T-bit
//          indices, shared by the sequencer, the datapath and the benches.
// Ports:   none (package).

package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ENCODE   = 3'd2,
    ST_INJECT   = 3'd3,
    ST_SYNDROME = 3'd4,
    ST_CORRECT  = 3'd5,
    ST_DONE     = 3'd6,
    ST_ILLEGAL  = 3'd7
  } state_t;

  // T[k] is high exactly while Q == k
  localparam int TBIT_IDLE     = 0;
  localparam int TBIT_LOAD     = 1;
  localparam int TBIT_ENCODE   = 2;
  localparam int TBIT_INJECT   = 3;
  localparam int TBIT_SYNDROME = 4;
  localparam int TBIT_CORRECT  = 5;
  localparam int TBIT_DONE     = 6;

endpackage

// File: rtl/hamming_sequencer_if.sv
// rtl/hamming_sequencer_if.sv - host/datapath bundle of the Hamming transaction sequencer
//
// Purpose: groups the start/result handshakes, the datapath enables, the state
//          observation outputs and the corrected-word counter.
// Ports:   start/start_ready   transaction request handshake
//          syn_nonzero         decoder syndrome != 0
//          out_valid/out_ready result handshake, out_corrected qualifier
//          load_en..cor_en     datapath enables (taps of T)
//          Q, T                state code and its one-hot timing word
//          err_cnt, clr_cnt    saturating corrected-word count and its clear
// Modports: master = sequencer side, slave = host/datapath side.

interface hamming_sequencer_if #(
  parameter int CNT_W = 8
);

  logic             start;
  logic             start_ready;
  logic             syn_nonzero;
  logic             out_ready;
  logic             out_valid;
  logic             out_corrected;
  logic             load_en;
  logic             enc_en;
  logic             inj_en;
  logic             syn_en;
  logic             cor_en;
  logic [2:0]       Q;
  logic [7:0]       T;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_cnt;

  modport master (
    input  start, syn_nonzero, out_ready, clr_cnt,
    output start_ready, out_valid, out_corrected,
    output load_en, enc_en, inj_en, syn_en, cor_en,
    output Q, T, err_cnt
  );

  modport slave (
    output start, syn_nonzero, out_ready, clr_cnt,
    input  start_ready, out_valid, out_corrected,
    input  load_en, enc_en, inj_en, syn_en, cor_en,
    input  Q, T, err_cnt
  );

endinterface

// File: rtl/hamming_t_decode.sv
// rtl/hamming_t_decode.sv - 3-to-8 one-hot decoder from state code to timing word
//
// Purpose: T[Q] = 1 for legal codes; the illegal code 7 decodes to all zeros so
//          that no datapath enable can fire while the FSM recovers.
// Ports:   i_q  in  3  registered state code
//          o_t  out 8  one-hot timing word

module hamming_t_decode (
  input  logic [2:0] i_q,
  output logic [7:0] o_t
);

  always_comb begin
    o_t = 8'h00;
    if (i_q != 3'd7) begin
      o_t[i_q] = 1'b1;
    end
  end

endmodule

// File: rtl/hamming_sequencer.sv
// rtl/hamming_sequencer.sv - sequencer for one Hamming(7,4) load/encode/inject/syndrome/correct transaction
//
// Purpose: owns the state register Q, decodes it into the one-hot timing word T,
//          taps the datapath enables from T, and keeps the out_corrected flag and
//          the saturating corrected-word counter.
// Ports:   clk   in  1  system clock
//          rst   in  1  synchronous active-high reset
//          bus   master modport of hamming_sequencer_if (handshakes, enables, Q/T, err_cnt)
// Params:  INJECT_EN  1 visits INJECT, 0 skips it
//          CNT_W      err_cnt width, must match the interface instance

module hamming_sequencer
  import hamming_pkg::*;
#(
  parameter int INJECT_EN = 1,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  hamming_sequencer_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       w_t;
  logic             r_corrected;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_enter_load;
  logic             w_enter_correct;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the illegal code falls into default and recovers to IDLE
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_next = bus.start ? ST_LOAD : ST_IDLE;
      ST_LOAD:     w_next = ST_ENCODE;
      ST_ENCODE:   w_next = (INJECT_EN != 0) ? ST_INJECT : ST_SYNDROME;
      ST_INJECT:   w_next = ST_SYNDROME;
      ST_SYNDROME: w_next = bus.syn_nonzero ? ST_CORRECT : ST_DONE;
      ST_CORRECT:  w_next = ST_DONE;
      ST_DONE:     w_next = bus.out_ready ? ST_IDLE : ST_DONE;
      default:     w_next = ST_IDLE;
    endcase
  end

  assign w_enter_load    = (r_state == ST_IDLE) && bus.start;
  assign w_enter_correct = (r_state == ST_SYNDROME) && bus.syn_nonzero;

  // Flag is per transaction: cleared when a new one is loaded, held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_corrected <= 1'b0;
    end else if (w_enter_load) begin
      r_corrected <= 1'b0;
    end else if (w_enter_correct) begin
      r_corrected <= 1'b1;
    end
  end

  // Clear has priority over a same-edge increment; count sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_enter_correct && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  hamming_t_decode u_t_decode (
    .i_q (r_state),
    .o_t (w_t)
  );

  assign bus.Q             = r_state;
  assign bus.T             = w_t;
  assign bus.start_ready   = (r_state == ST_IDLE);
  assign bus.out_valid     = (r_state == ST_DONE);
  assign bus.out_corrected = r_corrected;
  assign bus.load_en       = w_t[TBIT_LOAD];
  assign bus.enc_en        = w_t[TBIT_ENCODE];
  assign bus.inj_en        = w_t[TBIT_INJECT] & (INJECT_EN != 0);
  assign bus.syn_en        = w_t[TBIT_SYNDROME];
  assign bus.cor_en        = w_t[TBIT_CORRECT];
  assign bus.err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_hamming_sequencer.sv
// tb/tb_hamming_sequencer.sv - directed self-checking bench for hamming_sequencer

module tb_hamming_sequencer;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hamming_sequencer_if #(.CNT_W(8)) bus0 ();
  hamming_sequencer_if #(.CNT_W(8)) bus1 ();
  hamming_sequencer_if #(.CNT_W(2)) bus2 ();

  hamming_sequencer #(.INJECT_EN(1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  hamming_sequencer #(.INJECT_EN(0), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  hamming_sequencer #(.INJECT_EN(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus0.start = 0; bus0.syn_nonzero = 0; bus0.out_ready = 0; bus0.clr_cnt = 0;
    bus1.start = 0; bus1.syn_nonzero = 0; bus1.out_ready = 0; bus1.clr_cnt = 0;
    bus2.start = 0; bus2.syn_nonzero = 0; bus2.out_ready = 0; bus2.clr_cnt = 0;
    rst = 1;
    step();
    step();
    checks++; if (bus0.Q !== 3'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", bus0.Q); end
    checks++; if (bus0.T !== 8'h01) begin errors++; $display("FAIL reset_t: got %02h expected 01", bus0.T); end
    checks++; if (bus0.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus0.err_cnt); end
    checks++; if (bus0.start_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_hs: got ready=%b valid=%b expected 1 0", bus0.start_ready, bus0.out_valid); end
    checks++; if (bus0.out_corrected !== 1'b0) begin errors++; $display("FAIL reset_corr: got %b expected 0", bus0.out_corrected); end
    checks++; if ({bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en} !== 5'b0) begin errors++; $display("FAIL reset_en: got %05b expected 00000", {bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en}); end
    rst = 0;
  endtask

  task automatic test_no_correct;
    logic [7:0] exp [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h40, 8'h01};
    logic [7:0] e;
    bus0.start = 1; bus0.out_ready = 1; bus0.syn_nonzero = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      bus0.start = 0;
      e = exp[i];
      checks++; if (bus0.T !== e) begin errors++; $display("FAIL nocorr_t[%0d]: got %02h expected %02h", i, bus0.T, e); end
      checks++; if ({bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en} !== e[5:1]) begin errors++; $display("FAIL nocorr_en[%0d]: got %05b expected %05b", i, {bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en}, e[5:1]); end
      if (i == 4) begin
        checks++; if (bus0.out_valid !== 1'b1 || bus0.out_corrected !== 1'b0) begin errors++; $display("FAIL nocorr_done: got valid=%b corr=%b expected 1 0", bus0.out_valid, bus0.out_corrected); end
      end
    end
    checks++; if (bus0.err_cnt !== 8'd0) begin errors++; $display("FAIL nocorr_cnt: got %0d expected 0", bus0.err_cnt); end
  endtask

  task automatic test_correct;
    logic [7:0] exp [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    int cor_cycles = 0;
    bus0.start = 1; bus0.out_ready = 0; bus0.syn_nonzero = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus0.start = 0;
      if (bus0.cor_en === 1'b1) cor_cycles++;
      checks++; if (bus0.T !== exp[i]) begin errors++; $display("FAIL corr_t[%0d]: got %02h expected %02h", i, bus0.T, exp[i]); end
      checks++; if (bus0.err_cnt !== ((i >= 4) ? 8'd1 : 8'd0)) begin errors++; $display("FAIL corr_cnt[%0d]: got %0d expected %0d", i, bus0.err_cnt, (i >= 4) ? 1 : 0); end
    end
    checks++; if (bus0.out_corrected !== 1'b1) begin errors++; $display("FAIL corr_flag: got %b expected 1", bus0.out_corrected); end
    checks++; if (cor_cycles != 1) begin errors++; $display("FAIL corr_en_len: got %0d expected 1", cor_cycles); end
    bus0.syn_nonzero = 0;
  endtask

  task automatic test_done_hold;
    for (int i = 0; i < 5; i++) begin
      bus0.start = (i == 2);
      step();
      checks++; if (bus0.Q !== 3'd6 || bus0.out_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d]: got q=%0d valid=%b expected 6 1", i, bus0.Q, bus0.out_valid); end
    end
    bus0.start = 0;
    bus0.out_ready = 1;
    step();
    checks++; if (bus0.Q !== 3'd0 || bus0.start_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got q=%0d ready=%b expected 0 1", bus0.Q, bus0.start_ready); end
    step();
    checks++; if (bus0.Q !== 3'd0) begin errors++; $display("FAIL hold_noqueue: got q=%0d expected 0", bus0.Q); end
  endtask

  task automatic test_back_to_back;
    bus0.start = 1; bus0.out_ready = 0; bus0.syn_nonzero = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus0.start = 0;
    end
    checks++; if (bus0.Q !== 3'd6) begin errors++; $display("FAIL b2b_done: got q=%0d expected 6", bus0.Q); end
    bus0.syn_nonzero = 0;
    bus0.start = 1; bus0.out_ready = 1;
    step();
    checks++; if (bus0.Q !== 3'd0 || bus0.out_corrected !== 1'b1) begin errors++; $display("FAIL b2b_bubble: got q=%0d corr=%b expected 0 1", bus0.Q, bus0.out_corrected); end
    step();
    bus0.start = 0;
    checks++; if (bus0.Q !== 3'd1 || bus0.out_corrected !== 1'b0) begin errors++; $display("FAIL b2b_load: got q=%0d corr=%b expected 1 0", bus0.Q, bus0.out_corrected); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus0.Q !== 3'd0 || bus0.err_cnt !== 8'd2) begin errors++; $display("FAIL b2b_end: got q=%0d cnt=%0d expected 0 2", bus0.Q, bus0.err_cnt); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    bus2.syn_nonzero = 1; bus2.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      bus2.start = 1;
      for (int i = 0; i < 7; i++) begin
        step();
        bus2.start = 0;
      end
      checks++; if (bus2.err_cnt !== exp[k] || bus2.Q !== 3'd0) begin errors++; $display("FAIL sat[%0d]: got cnt=%0d q=%0d expected %0d 0", k, bus2.err_cnt, bus2.Q, exp[k]); end
    end
    bus2.start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus2.start = 0;
    end
    checks++; if (bus2.Q !== 3'd4) begin errors++; $display("FAIL clr_pre: got q=%0d expected 4", bus2.Q); end
    bus2.clr_cnt = 1;
    step();
    bus2.clr_cnt = 0;
    checks++; if (bus2.err_cnt !== 2'd0 || bus2.Q !== 3'd5) begin errors++; $display("FAIL clr_wins: got cnt=%0d q=%0d expected 0 5", bus2.err_cnt, bus2.Q); end
    step();
    step();
    bus2.syn_nonzero = 0;
  endtask

  task automatic test_no_inject;
    logic [7:0] exp_a [5] = '{8'h02, 8'h04, 8'h10, 8'h40, 8'h01};
    logic [7:0] exp_b [6] = '{8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h01};
    logic inj_seen = 1'b0;
    bus1.out_ready = 1; bus1.syn_nonzero = 0; bus1.start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      bus1.start = 0;
      if (bus1.inj_en !== 1'b0) inj_seen = 1'b1;
      checks++; if (bus1.T !== exp_a[i]) begin errors++; $display("FAIL noinj_a[%0d]: got %02h expected %02h", i, bus1.T, exp_a[i]); end
    end
    bus1.syn_nonzero = 1; bus1.start = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus1.start = 0;
      if (bus1.inj_en !== 1'b0) inj_seen = 1'b1;
      checks++; if (bus1.T !== exp_b[i]) begin errors++; $display("FAIL noinj_b[%0d]: got %02h expected %02h", i, bus1.T, exp_b[i]); end
    end
    checks++; if (inj_seen !== 1'b0) begin errors++; $display("FAIL noinj_injen: got %b expected 0", inj_seen); end
    checks++; if (bus1.err_cnt !== 8'd1) begin errors++; $display("FAIL noinj_cnt: got %0d expected 1", bus1.err_cnt); end
    bus1.syn_nonzero = 0;
  endtask

  task automatic test_reset_mid_and_illegal;
    bus0.out_ready = 1; bus0.syn_nonzero = 1; bus0.start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus0.start = 0;
    end
    checks++; if (bus0.Q !== 3'd4) begin errors++; $display("FAIL rstmid_pre: got q=%0d expected 4", bus0.Q); end
    rst = 1;
    step();
    rst = 0;
    bus0.syn_nonzero = 0;
    checks++; if (bus0.Q !== 3'd0 || bus0.T !== 8'h01) begin errors++; $display("FAIL rstmid: got q=%0d t=%02h expected 0 01", bus0.Q, bus0.T); end
    checks++; if (bus0.out_corrected !== 1'b0 || bus0.err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_regs: got corr=%b cnt=%0d expected 0 0", bus0.out_corrected, bus0.err_cnt); end
    force dut0.r_state = ST_ILLEGAL;
    #1;
    checks++; if (bus0.T !== 8'h00) begin errors++; $display("FAIL illegal_t: got %02h expected 00", bus0.T); end
    checks++; if ({bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en, bus0.start_ready, bus0.out_valid} !== 7'b0) begin errors++; $display("FAIL illegal_en: got %07b expected 0000000", {bus0.cor_en, bus0.syn_en, bus0.inj_en, bus0.enc_en, bus0.load_en, bus0.start_ready, bus0.out_valid}); end
    release dut0.r_state;
    step();
    checks++; if (bus0.Q !== 3'd0 || bus0.T !== 8'h01) begin errors++; $display("FAIL illegal_recover: got q=%0d t=%02h expected 0 01", bus0.Q, bus0.T); end
  endtask

  initial begin
    test_reset();
    test_no_correct();
    test_correct();
    test_done_hold();
    test_back_to_back();
    test_saturate();
    test_no_inject();
    test_reset_mid_and_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
